// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the W-stage result with a 4-entry in-order MDU result FIFO.
// Optional commit trace is enabled by defining WB_TRACE_EN.
module wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic [31:0] pipe_pc,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    input  logic [31:0] mdu_pc,
    output logic        RegWrite,
    output logic [4:0]  A3,
    output logic [31:0] WD,
    output logic [31:0] PC_W,
    output logic [31:0] pending,
    output logic [2:0]  fifo_cnt
);

    localparam int unsigned Depth = 4;

    logic [4:0]       addr_q [Depth];
    logic [31:0]      data_q [Depth];
    logic [31:0]      pc_q   [Depth];
    logic [Depth-1:0] live_q, live_d;
    logic [1:0]       rd_ptr_q, wr_ptr_q;
    logic [2:0]       cnt_q, cnt_d;

    logic             pipe_take, pop, push;
    logic             we_d;
    logic [4:0]       a3_d;
    logic [31:0]      wd_d, pc_d;

    assign mdu_ready = reset && (cnt_q < 3'd4);
    assign pipe_take = pipe_we && (pipe_addr != 5'd0);
    assign pop       = !pipe_take && (cnt_q != 3'd0);
    // $0 results complete the handshake but are never queued.
    assign push      = mdu_valid && mdu_ready && (mdu_addr != 5'd0);
    assign fifo_cnt  = cnt_q;

    // A pipe write is younger than every queued entry, so it kills matching ones;
    // a same-edge push is younger still and lands live.
    always_comb begin
        live_d = live_q;
        if (pipe_take) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                if (addr_q[i] == pipe_addr) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            live_d[wr_ptr_q] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        we_d = 1'b0;
        a3_d = A3;
        wd_d = WD;
        pc_d = PC_W;
        if (pipe_take) begin
            we_d = 1'b1;
            a3_d = pipe_addr;
            wd_d = pipe_data;
            pc_d = pipe_pc;
        end else if (pop) begin
            // Dead entries burn the pop cycle without a write.
            we_d = live_q[rd_ptr_q];
            if (live_q[rd_ptr_q]) begin
                a3_d = addr_q[rd_ptr_q];
                wd_d = data_q[rd_ptr_q];
                pc_d = pc_q[rd_ptr_q];
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (live_q[i]) begin
                pending[addr_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            RegWrite <= 1'b0;
            A3       <= 5'd0;
            WD       <= 32'd0;
            PC_W     <= 32'd0;
            live_q   <= '0;
            rd_ptr_q <= 2'd0;
            wr_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
        end else begin
            RegWrite <= we_d;
            A3       <= a3_d;
            WD       <= wd_d;
            PC_W     <= pc_d;
            live_q   <= live_d;
            cnt_q    <= cnt_d;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
        end
    end

    // Payload needs no reset; live bits gate its visibility.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            addr_q[wr_ptr_q] <= mdu_addr;
            data_q[wr_ptr_q] <= mdu_data;
            pc_q[wr_ptr_q]   <= mdu_pc;
        end
    end

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && we_d) begin
            $display("%0t@%h: $%0d <= %h", $time, pc_d, a3_d, wd_d);
        end
    end
`else
    // Untraced build: no simulation output.
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: scoreboard of expected register-file writes
// plus directed per-scenario checks of FIFO occupancy, pending and handshake.
module tb_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic [31:0] pipe_pc;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic [31:0] mdu_pc;
    logic        RegWrite;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] PC_W;
    logic [31:0] pending;
    logic [2:0]  fifo_cnt;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } wr_t;

    wr_t exp_q[$];
    int  vectors;
    int  miscompares;

    wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .pipe_we   (pipe_we),
        .pipe_addr (pipe_addr),
        .pipe_data (pipe_data),
        .pipe_pc   (pipe_pc),
        .mdu_valid (mdu_valid),
        .mdu_ready (mdu_ready),
        .mdu_addr  (mdu_addr),
        .mdu_data  (mdu_data),
        .mdu_pc    (mdu_pc),
        .RegWrite  (RegWrite),
        .A3        (A3),
        .WD        (WD),
        .PC_W      (PC_W),
        .pending   (pending),
        .fifo_cnt  (fifo_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    // Every committed write must match the oldest expected write.
    always @(negedge clk) begin
        if (RegWrite === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write: got $%0d <= %h @%h, none expected", A3, WD, PC_W);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({A3, WD, PC_W} !== e) begin
                    miscompares++;
                    $display("FAIL commit: got $%0d <= %h @%h, want $%0d <= %h @%h",
                             A3, WD, PC_W, e.a, e.d, e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_we   = 1'b0;
        pipe_addr = 5'd0;
        pipe_data = 32'd0;
        pipe_pc   = 32'd0;
        mdu_valid = 1'b0;
        mdu_addr  = 5'd0;
        mdu_data  = 32'd0;
        mdu_pc    = 32'd0;
    endtask

    task automatic drive_pipe(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        pipe_we   = 1'b1;
        pipe_addr = a;
        pipe_data = d;
        pipe_pc   = pc;
        if (a != 5'd0) exp_q.push_back('{a: a, d: d, pc: pc});
    endtask

    task automatic drive_mdu(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        mdu_valid = 1'b1;
        mdu_addr  = a;
        mdu_data  = d;
        mdu_pc    = pc;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        tick();
        tick();
        vectors++;
        if ({RegWrite, A3, WD, PC_W} !== 70'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b %0h %0h %0h want all 0", RegWrite, A3, WD, PC_W);
        end
        vectors++;
        if (fifo_cnt !== 3'd0 || pending !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_fifo: got cnt %0d pending %h want 0 0", fifo_cnt, pending);
        end
        vectors++;
        if (mdu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_low: got %b want 0", mdu_ready);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (mdu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready_release: got %b want 1", mdu_ready);
        end
    endtask

    task automatic test_pipe_only();
        drive_pipe(5'd5, 32'h1234_5678, 32'h3000);
        tick();
        idle_inputs();
        vectors++;
        if ({RegWrite, A3, WD, PC_W} !== {1'b1, 5'd5, 32'h1234_5678, 32'h3000}) begin
            miscompares++;
            $display("FAIL pipe_only: got %b $%0d %h %h want 1 $5 12345678 00003000",
                     RegWrite, A3, WD, PC_W);
        end
        tick();
        vectors++;
        if ({RegWrite, A3, WD, PC_W} !== {1'b0, 5'd5, 32'h1234_5678, 32'h3000}) begin
            miscompares++;
            $display("FAIL hold: got %b $%0d %h %h want 0 $5 12345678 00003000",
                     RegWrite, A3, WD, PC_W);
        end
    endtask

    task automatic test_priority();
        drive_pipe(5'd9, 32'h91, 32'h4000);
        drive_mdu(5'd8, 32'hAA, 32'h3F00);
        tick();
        idle_inputs();
        vectors++;
        if (fifo_cnt !== 3'd1 || pending !== 32'h100) begin
            miscompares++;
            $display("FAIL prio_queued: got cnt %0d pending %h want 1 00000100", fifo_cnt, pending);
        end
        for (int i = 0; i < 2; i++) begin
            drive_pipe(5'd9, 32'h92 + i, 32'h4004 + 4 * i);
            tick();
            idle_inputs();
            vectors++;
            if (fifo_cnt !== 3'd1) begin
                miscompares++;
                $display("FAIL prio_hold_cnt: got %0d want 1", fifo_cnt);
            end
        end
        exp_q.push_back('{a: 5'd8, d: 32'hAA, pc: 32'h3F00});
        tick();
        vectors++;
        if (fifo_cnt !== 3'd0 || pending !== 32'd0) begin
            miscompares++;
            $display("FAIL prio_drain: got cnt %0d pending %h want 0 0", fifo_cnt, pending);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 5; i++) begin
            drive_pipe(5'd1, 32'h100 + i, 32'h5000 + 4 * i);
            drive_mdu(5'(10 + i), 32'h200 + i, 32'h6000 + 4 * i);
            tick();
            if (i < 4) begin
                vectors++;
                if (fifo_cnt !== 3'(i + 1)) begin
                    miscompares++;
                    $display("FAIL full_fill: got %0d want %0d", fifo_cnt, i + 1);
                end
            end
        end
        vectors++;
        if (fifo_cnt !== 3'd4 || mdu_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_stall: got cnt %0d ready %b want 4 0", fifo_cnt, mdu_ready);
        end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{a: 5'(10 + i), d: 32'h200 + i, pc: 32'h6000 + 4 * i});
        end
        pipe_we = 1'b0;
        tick();
        vectors++;
        if (fifo_cnt !== 3'd3 || mdu_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_first_pop: got cnt %0d ready %b want 3 1", fifo_cnt, mdu_ready);
        end
        tick();
        mdu_valid = 1'b0;
        vectors++;
        if (fifo_cnt !== 3'd3) begin
            miscompares++;
            $display("FAIL full_push_pop: got %0d want 3", fifo_cnt);
        end
        idle_inputs();
        repeat (3) tick();
        vectors++;
        if (fifo_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL full_drain: got %0d want 0", fifo_cnt);
        end
    endtask

    task automatic test_kill();
        drive_pipe(5'd2, 32'h2222, 32'h7000);
        drive_mdu(5'd3, 32'h11, 32'h6F00);
        tick();
        idle_inputs();
        vectors++;
        if (pending !== 32'h8) begin
            miscompares++;
            $display("FAIL kill_pending_set: got %h want 00000008", pending);
        end
        drive_pipe(5'd3, 32'h22, 32'h7004);
        tick();
        idle_inputs();
        vectors++;
        if (pending !== 32'd0 || fifo_cnt !== 3'd1) begin
            miscompares++;
            $display("FAIL kill_edge: got pending %h cnt %0d want 0 1", pending, fifo_cnt);
        end
        tick();
        vectors++;
        if (RegWrite !== 1'b0 || fifo_cnt !== 3'd0 || A3 !== 5'd3 || WD !== 32'h22) begin
            miscompares++;
            $display("FAIL kill_dead_pop: got we %b cnt %0d $%0d %h want 0 0 $3 22",
                     RegWrite, fifo_cnt, A3, WD);
        end
    endtask

    task automatic test_zero();
        drive_pipe(5'd4, 32'h44, 32'h8000);
        drive_mdu(5'd0, 32'hDEAD, 32'h7F00);
        tick();
        idle_inputs();
        vectors++;
        if (fifo_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL zero_mdu: got %0d want 0", fifo_cnt);
        end
        drive_pipe(5'd0, 32'hBAD, 32'h8004);
        tick();
        idle_inputs();
        vectors++;
        if (RegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_pipe_drop: got %b want 0", RegWrite);
        end
        drive_pipe(5'd4, 32'h45, 32'h8008);
        drive_mdu(5'd6, 32'h66, 32'h7F04);
        tick();
        exp_q.push_back('{a: 5'd6, d: 32'h66, pc: 32'h7F04});
        mdu_valid = 1'b0;
        pipe_addr = 5'd0;
        tick();
        idle_inputs();
        vectors++;
        if (RegWrite !== 1'b1 || A3 !== 5'd6 || fifo_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL zero_pipe_pop: got we %b $%0d cnt %0d want 1 $6 0", RegWrite, A3, fifo_cnt);
        end
    endtask

    task automatic test_same_edge();
        drive_pipe(5'd7, 32'h1, 32'h9000);
        drive_mdu(5'd7, 32'h2, 32'h8F00);
        tick();
        idle_inputs();
        exp_q.push_back('{a: 5'd7, d: 32'h2, pc: 32'h8F00});
        vectors++;
        if (pending !== 32'h80 || fifo_cnt !== 3'd1) begin
            miscompares++;
            $display("FAIL same_edge_live: got pending %h cnt %0d want 00000080 1", pending, fifo_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive_pipe(5'd1, 32'h300 + i, 32'hA000 + 4 * i);
            drive_mdu(5'(20 + i), 32'h400 + i, 32'hB000 + 4 * i);
            tick();
        end
        idle_inputs();
        vectors++;
        if (fifo_cnt !== 3'd3) begin
            miscompares++;
            $display("FAIL mid_fill: got %0d want 3", fifo_cnt);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if ({RegWrite, A3, WD, PC_W, pending, fifo_cnt} !== 105'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got we %b $%0d %h %h pending %h cnt %0d want all 0",
                     RegWrite, A3, WD, PC_W, pending, fifo_cnt);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (RegWrite !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_no_write: got %b want 0 (cycle %0d)", RegWrite, i);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_pipe_only();
        test_priority();
        test_full();
        test_kill();
        test_zero();
        test_same_edge();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes: got %0d outstanding want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL use one clock and synchronous reset; reset is synchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-low reset; 0 at a clk edge resets all state.
REQ-004 pipe_we  input  1  W-stage result valid this cycle; always accepted, no backpressure.
REQ-005 pipe_addr  input  5  W-stage destination register.
REQ-006 pipe_data  input  32  W-stage result value.
REQ-007 pipe_pc  input  32  PC of the W-stage instruction.
REQ-008 mdu_valid  input  1  MDU result offered.
REQ-009 mdu_ready  output  1  block can accept an MDU result this cycle.
REQ-010 mdu_addr, mdu_data, mdu_pc  input  5/32/32  MDU result destination, value and PC.
REQ-011 RegWrite  output  1  register-file write enable, registered.
REQ-012 A3  output  5  register-file write address, registered.
REQ-013 WD  output  32  register-file write data, registered.
REQ-014 PC_W  output  32  PC of the committed write, registered.
REQ-015 pending  output  32  bit r = 1 iff a live FIFO entry targets register r.
REQ-016 fifo_cnt  output  3  occupied FIFO slots, 0..4.

Function
REQ-017 MDU results SHALL be buffered in a 4-entry in-order FIFO; each entry holds addr, data, pc and a live bit.
REQ-018 Push rule: mdu_valid && mdu_ready at an edge pushes one entry; mdu_ready = (fifo_cnt < 4), with no same-cycle pop credit.
REQ-019 An MDU result with mdu_addr = 0 SHALL complete the handshake but SHALL NOT be enqueued.
REQ-020 Output selection per edge: if pipe_we && pipe_addr != 0, register the pipe write; otherwise, if the FIFO is non-empty, pop the head and register it; otherwise RegWrite <= 0.
REQ-021 A popped entry SHALL drive RegWrite <= its live bit; a dead entry consumes the pop cycle with RegWrite <= 0.
REQ-022 Latency: input at edge n SHALL appear on RegWrite/A3/WD/PC_W after edge n (one cycle).
REQ-023 A pipe write with pipe_addr = 0 SHALL be dropped (RegWrite <= 0) and SHALL leave the FIFO free to pop that cycle.
REQ-024 Ordering: a pipe write to r SHALL clear the live bit of every FIFO entry with addr r at the same edge, because the pipe result is younger.
REQ-025 An MDU result pushed at the same edge as a pipe write to the same r is younger; it SHALL be enqueued live.
REQ-026 Simultaneous push and pop SHALL leave fifo_cnt unchanged; the FIFO pointers SHALL wrap modulo 4.
REQ-027 pending SHALL be combinational from the FIFO contents and SHALL exclude dead entries.
REQ-028 A3, WD and PC_W SHALL hold their last values while RegWrite = 0.

Reset
REQ-029 On reset = 0 at an edge: RegWrite=0, A3=0, WD=0, PC_W=0, the FIFO is emptied (fifo_cnt=0, pending=0), and the pointers = 0.
REQ-030 mdu_ready SHALL be 0 while reset = 0, and 1 from the first cycle after release.
REQ-031 Reset mid-operation SHALL discard all queued entries without issuing a write.

Configuration
REQ-032 Macro WB_TRACE_EN: when it is defined, each edge that sets RegWrite=1 SHALL print "<time>@<PC_W hex>: $<A3 dec> <= <WD hex>".
REQ-033 When WB_TRACE_EN is not defined, the block SHALL print nothing, and its cycle behaviour SHALL be identical to the traced build.

Verification
REQ-034 Pipe only: pipe_we=1, addr=5, data=0x12345678, pc=0x3000 at edge n -> RegWrite=1, A3=5, WD=0x12345678, PC_W=0x3000 after edge n.
REQ-035 Priority: the FIFO holds {r8=0xAA}; pipe writes r9 for 3 cycles -> r9 is committed 3 times, then r8=0xAA is committed on the next idle cycle; fifo_cnt goes 1->0.
REQ-036 Full: push 4 MDU results with pipe busy -> fifo_cnt=4, mdu_ready=0; the 5th offer is held and is accepted the cycle after the first pop.
REQ-037 Kill: the FIFO holds {r3=0x11}; pipe writes r3=0x22 -> r3=0x22 is committed, then the r3 entry pops with RegWrite=0; pending[3] clears at the kill edge.
REQ-038 $0: mdu_addr=0 is accepted with fifo_cnt unchanged; pipe_addr=0 gives RegWrite=0 and a queued entry pops in that cycle.
REQ-039 Reset: assert reset=0 with fifo_cnt=3 -> next cycle all outputs are 0, pending=0, and no write is issued after release.
